// File: rtl/wbu_commit.sv
// Writeback/commit stage: retires ALU results in order, writes the GPR file or
// raises a precise exception with a held flush. Optional trace ports: WBU_COMMIT_TRACE_EN.
module wbu_commit #(
    parameter int DATA_W = 32,
    parameter int ETW_W  = 8,
    parameter int BRID_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S_ALU_WBU_res_tvalid,
    output logic              S_ALU_WBU_res_tready,
    input  logic [DATA_W-1:0] res_val,
    input  logic [4:0]        res_rd,
    input  logic              res_rd_wen,
    input  logic [DATA_W-1:0] res_PC,
    input  logic              res_is_delayslot,
    input  logic [BRID_W-1:0] res_branch_id,
    input  logic [ETW_W-1:0]  res_ETW,
    output logic              rf_wen,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              exc_valid,
    output logic [4:0]        exc_code,
    output logic [DATA_W-1:0] exc_epc,
    output logic              exc_bd,
    output logic              M_WBU_flush_tvalid,
    input  logic              M_WBU_flush_tready,
    output logic [1:0]        flush_kind,
    output logic [BRID_W-1:0] flush_branch_id,
`ifdef WBU_COMMIT_TRACE_EN
    output logic [DATA_W-1:0] debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata,
`endif
    output logic [31:0]       commit_cnt
);

    // state | meaning
    // RUN   | commit results, raise exception on non-zero ETW
    // FLUSH | flush broadcast held until acked; incoming results are squashed
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [1:0] FLUSH_EXC = 2'b01;
    localparam int         ENC_W     = (ETW_W > 32) ? 32 : ETW_W;

    state_t state, state_nx;

    logic              xfer;
    logic              is_exc;
    logic              rf_wen_d, exc_valid_d, flush_tvalid_d, exc_bd_d;
    logic [4:0]        rf_waddr_d, exc_code_d;
    logic [DATA_W-1:0] rf_wdata_d, exc_epc_d;
    logic [1:0]        flush_kind_d;
    logic [BRID_W-1:0] flush_bid_d;
    logic [31:0]       commit_cnt_d;

    function automatic logic [4:0] lowest_set(input logic [ETW_W-1:0] etw);
        logic [4:0] code;
        code = 5'd0;
        for (int i = ENC_W - 1; i >= 0; i--) begin
            if (etw[i]) code = i[4:0];
        end
        return code;
    endfunction

    assign S_ALU_WBU_res_tready = (state == RUN) | (state == FLUSH);
    assign xfer   = S_ALU_WBU_res_tvalid & S_ALU_WBU_res_tready;
    assign is_exc = |res_ETW;

    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (xfer && is_exc) state_nx = FLUSH;
            FLUSH:   if (M_WBU_flush_tready && M_WBU_flush_tvalid) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        rf_wen_d       = 1'b0;
        exc_valid_d    = 1'b0;
        rf_waddr_d     = rf_waddr;
        rf_wdata_d     = rf_wdata;
        exc_code_d     = exc_code;
        exc_epc_d      = exc_epc;
        exc_bd_d       = exc_bd;
        flush_tvalid_d = M_WBU_flush_tvalid;
        flush_kind_d   = flush_kind;
        flush_bid_d    = flush_branch_id;
        commit_cnt_d   = commit_cnt;
        case (state)
            RUN: begin
                if (xfer && !is_exc) begin
                    rf_wen_d     = res_rd_wen & (res_rd != 5'd0);
                    rf_waddr_d   = res_rd;
                    rf_wdata_d   = res_val;
                    commit_cnt_d = commit_cnt + 32'd1;
                end else if (xfer) begin
                    exc_valid_d    = 1'b1;
                    exc_code_d     = lowest_set(res_ETW);
                    exc_epc_d      = res_is_delayslot ? res_PC - DATA_W'(4) : res_PC;
                    exc_bd_d       = res_is_delayslot;
                    flush_tvalid_d = 1'b1;
                    flush_kind_d   = FLUSH_EXC;
                    flush_bid_d    = res_branch_id;
                end
            end
            FLUSH: begin
                // Younger results are consumed but never retire.
                if (M_WBU_flush_tready) flush_tvalid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wen             <= 1'b0;
            rf_waddr           <= 5'd0;
            rf_wdata           <= '0;
            exc_valid          <= 1'b0;
            exc_code           <= 5'd0;
            exc_epc            <= '0;
            exc_bd             <= 1'b0;
            M_WBU_flush_tvalid <= 1'b0;
            flush_kind         <= 2'b00;
            flush_branch_id    <= '0;
            commit_cnt         <= 32'd0;
        end else begin
            rf_wen             <= rf_wen_d;
            rf_waddr           <= rf_waddr_d;
            rf_wdata           <= rf_wdata_d;
            exc_valid          <= exc_valid_d;
            exc_code           <= exc_code_d;
            exc_epc            <= exc_epc_d;
            exc_bd             <= exc_bd_d;
            M_WBU_flush_tvalid <= flush_tvalid_d;
            flush_kind         <= flush_kind_d;
            flush_branch_id    <= flush_bid_d;
            commit_cnt         <= commit_cnt_d;
        end
    end

`ifdef WBU_COMMIT_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= 4'd0;
            debug_wb_rf_wnum  <= 5'd0;
            debug_wb_rf_wdata <= '0;
        end else begin
            debug_wb_rf_wen   <= {4{rf_wen_d}};
            debug_wb_rf_wnum  <= rf_waddr_d;
            debug_wb_rf_wdata <= rf_wdata_d;
            if (state == RUN && xfer) debug_wb_pc <= res_PC;
        end
    end
`endif

endmodule

// File: tb/tb_wbu_commit.sv
// Directed bench for wbu_commit: commits, exception/flush handshake,
// counter wrap, reset during flush and exception priority encoding.
module tb_wbu_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        tvalid;
    logic        tready;
    logic [31:0] val;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] pc;
    logic        ds;
    logic [3:0]  bid;
    logic [7:0]  etw;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        fl_tvalid;
    logic        fl_tready;
    logic [1:0]  fl_kind;
    logic [3:0]  fl_bid;
    logic [31:0] commit_cnt;
`ifdef WBU_COMMIT_TRACE_EN
    logic [31:0] dbg_pc;
    logic [3:0]  dbg_wen;
    logic [4:0]  dbg_wnum;
    logic [31:0] dbg_wdata;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    wbu_commit dut (
        .clk                  (clk),
        .rst                  (rst),
        .S_ALU_WBU_res_tvalid (tvalid),
        .S_ALU_WBU_res_tready (tready),
        .res_val              (val),
        .res_rd               (rd),
        .res_rd_wen           (rd_wen),
        .res_PC               (pc),
        .res_is_delayslot     (ds),
        .res_branch_id        (bid),
        .res_ETW              (etw),
        .rf_wen               (rf_wen),
        .rf_waddr             (rf_waddr),
        .rf_wdata             (rf_wdata),
        .exc_valid            (exc_valid),
        .exc_code             (exc_code),
        .exc_epc              (exc_epc),
        .exc_bd               (exc_bd),
        .M_WBU_flush_tvalid   (fl_tvalid),
        .M_WBU_flush_tready   (fl_tready),
        .flush_kind           (fl_kind),
        .flush_branch_id      (fl_bid),
`ifdef WBU_COMMIT_TRACE_EN
        .debug_wb_pc          (dbg_pc),
        .debug_wb_rf_wen      (dbg_wen),
        .debug_wb_rf_wnum     (dbg_wnum),
        .debug_wb_rf_wdata    (dbg_wdata),
`endif
        .commit_cnt           (commit_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [4:0] r, input logic [31:0] v, input logic w,
                        input logic [31:0] p, input logic d, input logic [3:0] b,
                        input logic [7:0] e);
        tvalid = 1'b1; rd = r; val = v; rd_wen = w; pc = p; ds = d; bid = b; etw = e;
    endtask

    task automatic idle();
        tvalid = 1'b0; rd = 5'd0; val = 32'd0; rd_wen = 1'b0;
        pc = 32'd0; ds = 1'b0; bid = 4'd0; etw = 8'd0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rf_wen"},    {31'd0, rf_wen},    32'd0);
        check({pfx, "_rf_waddr"},  {27'd0, rf_waddr},  32'd0);
        check({pfx, "_rf_wdata"},  rf_wdata,           32'd0);
        check({pfx, "_exc_valid"}, {31'd0, exc_valid}, 32'd0);
        check({pfx, "_exc_code"},  {27'd0, exc_code},  32'd0);
        check({pfx, "_exc_epc"},   exc_epc,            32'd0);
        check({pfx, "_exc_bd"},    {31'd0, exc_bd},    32'd0);
        check({pfx, "_fl_tvalid"}, {31'd0, fl_tvalid}, 32'd0);
        check({pfx, "_fl_kind"},   {30'd0, fl_kind},   32'd0);
        check({pfx, "_fl_bid"},    {28'd0, fl_bid},    32'd0);
        check({pfx, "_cnt"},       commit_cnt,         32'd0);
        check({pfx, "_tready"},    {31'd0, tready},    32'd1);
    endtask

    task automatic check_flush(input string pfx, input logic [3:0] b);
        check({pfx, "_fl_tvalid"}, {31'd0, fl_tvalid}, 32'd1);
        check({pfx, "_fl_kind"},   {30'd0, fl_kind},   32'd1);
        check({pfx, "_fl_bid"},    {28'd0, fl_bid},    {28'd0, b});
    endtask

    initial begin
        rst = 1'b0; fl_tready = 1'b0;
        idle();
        step(); step();
        check_all_zero("reset");

        // Three ALU results: only the first one writes a register.
        rst = 1'b1;
        send(5'd5, 32'h1234, 1'b1, 32'h100, 1'b0, 4'd0, 8'd0);
        step();
        check("c1_rf_wen",   {31'd0, rf_wen},   32'd1);
        check("c1_rf_waddr", {27'd0, rf_waddr}, 32'd5);
        check("c1_rf_wdata", rf_wdata,          32'h1234);
        check("c1_cnt",      commit_cnt,        32'd1);
        send(5'd0, 32'hFFFF, 1'b1, 32'h104, 1'b0, 4'd0, 8'd0);
        step();
        check("c2_rf_wen_r0", {31'd0, rf_wen}, 32'd0);
        check("c2_cnt",       commit_cnt,      32'd2);
        send(5'd7, 32'h77, 1'b0, 32'h108, 1'b0, 4'd0, 8'd0);
        step();
        check("c3_rf_wen_nowen", {31'd0, rf_wen}, 32'd0);
        check("c3_cnt",          commit_cnt,      32'd3);
        idle();
        step();
        check("idle_rf_wen", {31'd0, rf_wen}, 32'd0);
        check("idle_cnt",    commit_cnt,      32'd3);

        // Exception in a delay slot.
        send(5'd9, 32'hDEAD, 1'b1, 32'hBFC0_0100, 1'b1, 4'd3, 8'b0001_0000);
        step();
        check("e1_exc_valid", {31'd0, exc_valid}, 32'd1);
        check("e1_exc_code",  {27'd0, exc_code},  32'd4);
        check("e1_exc_epc",   exc_epc,            32'hBFC0_00FC);
        check("e1_exc_bd",    {31'd0, exc_bd},    32'd1);
        check("e1_rf_wen",    {31'd0, rf_wen},    32'd0);
        check("e1_cnt",       commit_cnt,         32'd3);
        check_flush("e1", 4'd3);

        // Flush held for 5 cycles; 4 younger results are squashed.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) send(5'(10 + i), 32'(i + 1), 1'b1, 32'(32'h200 + 4 * i), 1'b0,
                            4'(i + 7), (i == 2) ? 8'h02 : 8'h00);
            else idle();
            step();
            check("hold_exc_valid", {31'd0, exc_valid}, 32'd0);
            check("hold_rf_wen",    {31'd0, rf_wen},    32'd0);
            check("hold_cnt",       commit_cnt,         32'd3);
            check("hold_tready",    {31'd0, tready},    32'd1);
            check("hold_exc_epc",   exc_epc,            32'hBFC0_00FC);
            check_flush("hold", 4'd3);
        end

        // Ack with a same-cycle result: still discarded.
        fl_tready = 1'b1;
        send(5'd12, 32'h99, 1'b1, 32'h300, 1'b0, 4'd1, 8'd0);
        step();
        check("ack_fl_tvalid", {31'd0, fl_tvalid}, 32'd0);
        check("ack_rf_wen",    {31'd0, rf_wen},    32'd0);
        check("ack_cnt",       commit_cnt,         32'd3);
        fl_tready = 1'b0;
        send(5'd8, 32'h55, 1'b1, 32'h304, 1'b0, 4'd1, 8'd0);
        step();
        check("post_rf_wen",   {31'd0, rf_wen},   32'd1);
        check("post_rf_waddr", {27'd0, rf_waddr}, 32'd8);
        check("post_rf_wdata", rf_wdata,          32'h55);
        check("post_cnt",      commit_cnt,        32'd4);

        // Counter wrap.
        force dut.commit_cnt = 32'hFFFF_FFFF;
        #1 release dut.commit_cnt;
        send(5'd2, 32'h1, 1'b1, 32'h308, 1'b0, 4'd0, 8'd0);
        step();
        check("wrap_cnt",    commit_cnt,      32'd0);
        check("wrap_rf_wen", {31'd0, rf_wen}, 32'd1);

        // Exception outside a delay slot, then reset while flushing.
        send(5'd4, 32'h4, 1'b1, 32'h2000, 1'b0, 4'd5, 8'b0001_0000);
        step();
        check("e2_exc_epc", exc_epc,         32'h2000);
        check("e2_exc_bd",  {31'd0, exc_bd}, 32'd0);
        check_flush("e2", 4'd5);
        send(5'd6, 32'h6, 1'b1, 32'h2004, 1'b0, 4'd6, 8'd0);
        rst = 1'b0;
        step();
        check_all_zero("rst_flush");
        rst = 1'b1;
        send(5'd3, 32'hA, 1'b1, 32'h400, 1'b0, 4'd0, 8'd0);
        step();
        check("rr_rf_wen",   {31'd0, rf_wen},   32'd1);
        check("rr_rf_waddr", {27'd0, rf_waddr}, 32'd3);
        check("rr_rf_wdata", rf_wdata,          32'hA);
        check("rr_cnt",      commit_cnt,        32'd1);
        check("rr_fl_tvalid", {31'd0, fl_tvalid}, 32'd0);

        // Multiple ETW bits: lowest wins; PC-4 wraps below zero.
        send(5'd1, 32'h1, 1'b1, 32'h0000_0002, 1'b1, 4'd9, 8'b1000_0101);
        step();
        check("e3_exc_valid", {31'd0, exc_valid}, 32'd1);
        check("e3_exc_code",  {27'd0, exc_code},  32'd0);
        check("e3_exc_epc",   exc_epc,            32'hFFFF_FFFE);
        check("e3_cnt",       commit_cnt,         32'd1);
        check_flush("e3", 4'd9);
        idle();
        fl_tready = 1'b1;
        step();
        check("e3_exc_once",  {31'd0, exc_valid}, 32'd0);
        check("e3_fl_tvalid", {31'd0, fl_tvalid}, 32'd0);
        fl_tready = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wbu_commit.md
Name: wbu_commit

Overview:
- Writeback/commit stage directly downstream of the ALU. It consumes the ALU result message and retires instructions in order.
- Writes the GPR file, or raises a precise exception to CP0 when the exception-type word (ETW) is non-zero.
- Broadcasts a pipeline flush to upstream stages and holds it until acknowledged.
- Keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, width of data and PC.
- ETW_W, 8, exception-type word width; bit i set means exception code i.
- BRID_W, 4, branch_id width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- S_ALU_WBU_res_tvalid  in  1  result valid.
- S_ALU_WBU_res_tready  out  1  stage accepts result.
- res_val  in  DATA_W  result value.
- res_rd  in  5  destination GPR.
- res_rd_wen  in  1  write-enable from ALU (MOVN/MOVZ gating).
- res_PC  in  DATA_W  instruction PC.
- res_is_delayslot  in  1  instruction sits in a delay slot.
- res_branch_id  in  BRID_W  branch tag.
- res_ETW  in  ETW_W  accumulated exception bits.
- rf_wen  out  1  GPR write strobe.
- rf_waddr  out  5  GPR write address.
- rf_wdata  out  DATA_W  GPR write data.
- exc_valid  out  1  one-cycle exception request to CP0.
- exc_code  out  5  index of lowest set ETW bit.
- exc_epc  out  DATA_W  exception PC.
- exc_bd  out  1  branch-delay flag.
- M_WBU_flush_tvalid  out  1  flush request.
- M_WBU_flush_tready  in  1  flush accepted by all consumers.
- flush_kind  out  2  flush kind; 2'b01 = EXC, flush everything.
- flush_branch_id  out  BRID_W  tag of the faulting instruction.
- commit_cnt  out  32  retired-instruction count.

Behaviour:
- Reset (rst==0 at posedge):
  - state <= RUN.
  - rf_wen, exc_valid, M_WBU_flush_tvalid <= 0.
  - rf_waddr, rf_wdata, exc_code, exc_epc, exc_bd, flush_kind, flush_branch_id <= 0.
  - commit_cnt <= 0.
  - Reset mid-FLUSH abandons the flush.
- Handshake: transfer on tvalid & tready. tready = (state==RUN) | (state==FLUSH). The stage never stalls upstream.
- All outputs are registered. A transfer in cycle N shows its effect in cycle N+1. Strobes (rf_wen, exc_valid) are high for exactly one cycle.
- State RUN, transfer with ETW==0 (normal commit):
  - rf_wen <= res_rd_wen & (res_rd != 0); rf_waddr <= res_rd; rf_wdata <= res_val.
  - commit_cnt <= commit_cnt + 1 regardless of rd_wen. The counter wraps modulo 2^32.
- State RUN, transfer with ETW!=0 (exception):
  - No GPR write; commit_cnt is unchanged.
  - exc_valid <= 1; exc_code <= priority-encoded lowest set bit; exc_bd <= is_delayslot.
  - exc_epc <= is_delayslot ? PC-4 : PC, computed modulo 2^DATA_W.
  - M_WBU_flush_tvalid <= 1; flush_kind <= 2'b01; flush_branch_id <= res_branch_id.
  - state <= FLUSH.
- State FLUSH:
  - Any incoming transfer is accepted and discarded: no write, no count, no exception. These are younger, squashed instructions.
  - Flush outputs are held stable while tvalid & !tready.
  - On M_WBU_flush_tready with tvalid high: deassert tvalid next cycle, state <= RUN.
  - A transfer in the same cycle as the flush acknowledge is still discarded.
- No transfer in RUN: rf_wen and exc_valid read 0 next cycle.
- ETW bits at or above position 32 are ignored by the encoder when ETW_W > 32.

Optional Feature:
- Macro: WBU_COMMIT_TRACE_EN.
- When defined, adds four outputs: debug_wb_pc (DATA_W), debug_wb_rf_wen (4), debug_wb_rf_wnum (5), debug_wb_rf_wdata (DATA_W).
  - They are registered alongside rf_*.
  - debug_wb_rf_wen = {4{rf_wen}}.
  - debug_wb_pc holds the committing PC, and is also updated on an exception commit with rf_wen=0.
- When undefined, the ports and logic are absent and the core behaviour is identical.

Test Plan:
- Reset then three ALU results: rd=5/val=0x1234, rd=0/val=0xFFFF, rd=7/rd_wen=0.
  - Required: one rf write, to reg 5 with 0x1234.
  - Required: commit_cnt=3.
- ETW=8'b0001_0000, PC=0xBFC0_0100, is_delayslot=1, branch_id=3.
  - Next cycle: exc_valid=1 for one cycle, exc_code=4, exc_epc=0xBFC0_00FC, exc_bd=1.
  - Flush: flush tvalid=1, kind=01, branch_id=3.
- Flush held: tready=0 for 5 cycles while 4 younger results arrive.
  - Required: flush outputs stable.
  - Required: no rf_wen, commit_cnt unchanged.
  - On tready=1, tvalid drops the next cycle and the following result commits.
- Preload commit_cnt near wrap via 0xFFFF_FFFF commits (or force), then commit one more.
  - Required: commit_cnt=0.
- Assert rst=0 while in FLUSH with tvalid=1.
  - Required: next cycle all outputs are 0 and state is RUN.
  - A subsequent rd=3/val=0xA commits normally.
- ETW=8'b1000_0101.
  - Required: exc_code=0.
